// File: rtl/reg_word_serializer.sv
// Parallel-to-serial stage with valid/ready on both sides, frame first/last markers and backpressure.
// Optional macro SERIAL_PARITY_EN appends one even-parity bit after the data bits.
module reg_word_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             sout_first,
    output logic             sout_last,
    output logic             busy
);

`ifdef SERIAL_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int            CW       = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t               state, state_next;
    logic [FRAME_LEN-1:0] shreg, shreg_next, load_word, shifted;
    logic [CW-1:0]        cnt, cnt_next;
    logic                 in_shift, head;

`ifdef SERIAL_PARITY_EN
    logic parity;
    assign parity    = ^din;
    // The parity bit always trails the data, whichever end is sent first.
    assign load_word = MSB_FIRST ? {din, parity} : {parity, din};
`else
    assign load_word = din;
`endif

    assign head    = MSB_FIRST ? shreg[FRAME_LEN-1] : shreg[0];
    assign shifted = MSB_FIRST ? {shreg[FRAME_LEN-2:0], 1'b0}
                               : {1'b0, shreg[FRAME_LEN-1:1]};

    assign in_shift   = (state == SHIFT);
    assign sout_valid = in_shift;
    assign busy       = in_shift;
    assign sout       = in_shift & head;
    assign sout_first = in_shift && (cnt == '0);
    assign sout_last  = in_shift && (cnt == LAST_CNT);
    assign din_ready  = !clr && (!in_shift || (sout_last && sout_ready));

    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        cnt_next   = cnt;
        if (din_ready && din_valid) begin
            state_next = SHIFT;
            shreg_next = load_word;
            cnt_next   = '0;
        end else if (in_shift && sout_ready) begin
            if (sout_last) begin
                state_next = IDLE;
                shreg_next = '0;
                cnt_next   = '0;
            end else begin
                shreg_next = shifted;
                cnt_next   = cnt + CW'(1);
            end
        end
    end

    // NOTE: clr is synchronous, so it sits inside the clocked block and wins over every other input.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            cnt   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_reg_word_serializer.sv
// Directed bench for reg_word_serializer (WIDTH=4, MSB first); expected streams are hand-written
// as {word, parity}, and only the first FL bits apply when parity is disabled.
module tb_reg_word_serializer;

`ifdef SERIAL_PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       sout;
    logic       sout_valid;
    logic       sout_ready;
    logic       sout_first;
    logic       sout_last;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    reg_word_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .clr        (clr),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_ready (sout_ready),
        .sout_first (sout_first),
        .sout_last  (sout_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_bit(input string tag, input logic b, input logic f, input logic l);
        check({tag, "_sout"},  32'(sout),       32'(b));
        check({tag, "_first"}, 32'(sout_first), 32'(f));
        check({tag, "_last"},  32'(sout_last),  32'(l));
        check({tag, "_valid"}, 32'(sout_valid), 32'd1);
        check({tag, "_busy"},  32'(busy),       32'd1);
    endtask

    task automatic check_idle(input string tag);
        settle();
        check({tag, "_idle_valid"}, 32'(sout_valid), 32'd0);
        check({tag, "_idle_busy"},  32'(busy),       32'd0);
        check({tag, "_idle_ready"}, 32'(din_ready),  32'd1);
        check({tag, "_idle_sout"},  32'(sout),       32'd0);
    endtask

    // Offer a word in IDLE; after the capture edge din is scrambled to prove it is not re-sampled.
    task automatic send_word(input string tag, input logic [3:0] w);
        din       = w;
        din_valid = 1'b1;
        settle();
        check({tag, "_accept_ready"}, 32'(din_ready),  32'd1);
        check({tag, "_accept_valid"}, 32'(sout_valid), 32'd0);
        tick();
        din_valid = 1'b0;
        din       = ~w;
    endtask

    // Receive one frame; at bit stall_bit hold sout_ready low for stall_n cycles while offering a word.
    task automatic recv(input string tag, input logic [4:0] s, input int stall_bit, input int stall_n);
        for (int i = 0; i < FL; i++) begin
            if (i == stall_bit) begin
                sout_ready = 1'b0;
                din_valid  = 1'b1;
                din        = 4'hA;
                for (int k = 0; k < stall_n; k++) begin
                    settle();
                    check_bit({tag, "_stall"}, s[4-i], i == 0, i == FL - 1);
                    check({tag, "_stall_ready"}, 32'(din_ready), 32'd0);
                    tick();
                end
                sout_ready = 1'b1;
                din_valid  = 1'b0;
            end
            settle();
            check_bit(tag, s[4-i], i == 0, i == FL - 1);
            tick();
        end
        check_idle(tag);
    endtask

    initial begin
        logic [4:0] s1;
        logic [4:0] s2;

        clr        = 1'b1;
        din        = 4'h0;
        din_valid  = 1'b0;
        sout_ready = 1'b1;

        // Reset then idle
        tick();
        settle();
        check("rst_din_ready", 32'(din_ready), 32'd0);
        tick();
        clr = 1'b0;
        check_idle("rst");
        check("rst_first", 32'(sout_first), 32'd0);
        check("rst_last",  32'(sout_last),  32'd0);

        // Single frame 0101 (parity 0)
        send_word("single", 4'b0101);
        recv("single", 5'b01010, -1, 0);

        // Backpressure on bit 1 of 1100 (parity 0)
        send_word("bp", 4'b1100);
        recv("bp", 5'b11000, 1, 3);

        // Back-to-back 1010 then 0011 (both parity 0)
        s1        = 5'b10100;
        s2        = 5'b00110;
        din       = 4'b1010;
        din_valid = 1'b1;
        settle();
        check("b2b_accept_ready", 32'(din_ready), 32'd1);
        tick();
        din = 4'b0011;
        for (int i = 0; i < 2 * FL; i++) begin
            int j;
            j = i % FL;
            settle();
            check_bit("b2b", (i < FL) ? s1[4-j] : s2[4-j], j == 0, j == FL - 1);
            check("b2b_din_ready", 32'(din_ready), 32'(j == FL - 1));
            tick();
            if (i == FL - 1) din_valid = 1'b0;
        end
        check_idle("b2b");

        // Reset mid-frame on 1111, then 0001 (parity 1)
        send_word("abort", 4'b1111);
        for (int i = 0; i < 2; i++) begin
            settle();
            check_bit("abort", 1'b1, i == 0, 1'b0);
            tick();
        end
        clr = 1'b1;
        settle();
        check("abort_clr_ready", 32'(din_ready), 32'd0);
        tick();
        clr = 1'b0;
        check_idle("abort");
        check("abort_first", 32'(sout_first), 32'd0);
        check("abort_last",  32'(sout_last),  32'd0);
        send_word("after_abort", 4'b0001);
        recv("after_abort", 5'b00011, -1, 0);

        // 0111 (parity 1)
        send_word("par", 4'b0111);
        recv("par", 5'b01111, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_word_serializer.md
Name: reg_word_serializer

Overview:
- Downstream stage of the 4-bit D-flip-flop register.
- Takes the parallel register word through a valid/ready handshake.
- Shifts the word out serially, one bit per accepted cycle, with frame markers and backpressure.
- Feeds a single-wire link or a serial checker in the lab datapath.

Parameters:
- WIDTH, 4: parallel word width in bits; legal range 2..16.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous active-high reset.
- din  input  WIDTH  parallel word from the register stage.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  serializer accepts din this cycle.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout is meaningful.
- sout_ready  input  1  downstream consumes sout this cycle.
- sout_first  output  1  sout is the first bit of a frame.
- sout_last  output  1  sout is the last bit of a frame.
- busy  output  1  a frame is in progress.

Behaviour:
- One clock (clk); reset clr is synchronous and active-high.
- clr has priority over all other inputs.
- Reset values: state=IDLE, shift register=0, bit counter=0, sout=0, sout_valid=0, sout_first=0, sout_last=0, busy=0.
- din_ready is combinational; it is 1 only while not in reset.
- Reset mid-frame aborts the frame: no further bits are sent and the captured word is discarded.
- States: IDLE and SHIFT.
- IDLE:
  - sout_valid=0, busy=0, din_ready=1.
  - On din_valid=1, din is captured at the clock edge, the counter is cleared and the state moves to SHIFT.
  - The first bit appears on sout in the cycle after capture (1-cycle latency).
- SHIFT:
  - sout_valid=1, busy=1.
  - sout = shift-register head bit (MSB or LSB per MSB_FIRST).
  - sout_first=1 when counter=0.
  - sout_last=1 when counter=FRAME_LEN-1.
  - Transfer occurs on a cycle with sout_valid=1 and sout_ready=1: the register shifts by one and the counter increments.
  - With sout_ready=0, sout, the flags and the counter hold unchanged for any number of cycles.
- FRAME_LEN = WIDTH, or WIDTH+1 when the optional feature is enabled.
- Counter width is clog2(FRAME_LEN+1); it never exceeds FRAME_LEN-1.
- Back-to-back frames:
  - din_ready=1 also in SHIFT on a cycle where sout_last=1 and sout_ready=1.
  - If din_valid=1 on that cycle, the new word is captured and the state stays SHIFT with counter=0.
  - The next frame's first bit follows with no idle gap.
  - Otherwise the state returns to IDLE.
- din_valid in SHIFT (outside the last-bit transfer) is ignored; din_ready=0 and the word is not captured.
- din is sampled only on the capture edge; changes to din mid-frame have no effect.

Optional Feature:
- Macro: SERIAL_PARITY_EN.
- Defined:
  - One even-parity bit is appended after the data bits, so FRAME_LEN=WIDTH+1.
  - The parity bit is the XOR of the captured word, computed at capture.
  - sout_last marks the parity bit.
- Undefined:
  - No parity bit; FRAME_LEN=WIDTH.
  - sout_last marks the final data bit.
  - No parity logic is instantiated.

Test Plan:
- Reset then idle: clr=1 for 2 cycles, then clr=0 with din_valid=0 -> sout_valid=0, busy=0, din_ready=1, sout=0.
- Single frame, WIDTH=4, MSB_FIRST=1, din=4'b0101, sout_ready=1 -> sout sequence 0,1,0,1 on 4 consecutive cycles starting one cycle after capture; sout_first on bit 0, sout_last on bit 3, then IDLE.
- Backpressure: din=4'b1100, sout_ready=0 for 3 cycles on bit 1 -> sout holds 1, flags hold, no bit lost; full sequence 1,1,0,0.
- Back-to-back: din_valid held high with din=4'b1010 then 4'b0011 -> 8 contiguous valid bits 1,0,1,0,0,0,1,1; second word accepted on the sout_last cycle.
- Reset mid-frame: clr=1 after 2 bits of 4'b1111 -> next cycle sout_valid=0, busy=0; a new word 4'b0001 then sends 0,0,0,1 cleanly.
- SERIAL_PARITY_EN defined: din=4'b0111 -> sout 0,1,1,1,1 (parity=1) with sout_last on the 5th bit; din=4'b0101 -> parity bit 0.
